// File: rtl/mod_memaccess.sv
// Data-side memory access unit: runs one load (line read, beat select) or one store (addr + data beat) on the 64-bit bus.
// Optional store-to-load forwarding of the last completed store is enabled by defining MEMACCESS_LOAD_FORWARD_EN.
module mod_memaccess #(
   parameter logic [2:0] DATA_TAG   = 3'b010,
   parameter int         LINE_BEATS = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_reqFlag,
   input  logic [0:63] data_reqAddr,
   input  logic        store_reqFlag,
   input  logic [0:63] store_reqAddr,
   input  logic [0:63] store_data,
   input  logic        loadbuffer_done,
   output logic        load_done,
   output logic [0:63] load_buffer,
   output logic        memstage_active,
   output logic        store_memstage_active,
   output logic        store_opn,
   output logic        bus_reqcyc,
   output logic [0:63] bus_req,
   output logic [0:15] bus_reqtag,
   input  logic        bus_reqack,
   input  logic        bus_respcyc,
   input  logic [0:63] bus_resp,
   input  logic [0:15] bus_resptag,
   output logic        bus_respack
);

   // state   | meaning
   // IDLE    | waiting for a load or store request (store wins)
   // LD_REQ  | line read request on bus, waiting for reqack
   // LD_RESP | collecting line beats, keeping the addressed one
   // LD_DONE | load_buffer valid until MEM stage consumes it
   // ST_ADDR | store address beat on bus
   // ST_DATA | store data beat on bus
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LD_REQ  = 3'd1;
   localparam logic [2:0] S_LD_RESP = 3'd2;
   localparam logic [2:0] S_LD_DONE = 3'd3;
   localparam logic [2:0] S_ST_ADDR = 3'd4;
   localparam logic [2:0] S_ST_DATA = 3'd5;
   localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

   logic [2:0]  r_state;
   logic [2:0]  r_beat;
   logic [0:60] r_addr;
   logic [0:63] r_data;
   logic [0:63] r_load_buffer;
   logic        w_beat_ok;
   logic [0:63] w_bus_req;
   logic        w_unused_bits;

   // Byte-in-doubleword offsets and the tag's non-type fields carry no meaning here.
   assign w_unused_bits = ^{data_reqAddr[61:63], store_reqAddr[61:63],
                            bus_resptag[0], bus_resptag[4:15]};

   assign w_beat_ok = (r_state == S_LD_RESP) && bus_respcyc && (bus_resptag[1:3] == DATA_TAG);

`ifdef MEMACCESS_LOAD_FORWARD_EN
   logic [0:60] r_fwd_addr;
   logic [0:63] r_fwd_data;
   logic        r_fwd_valid;
   logic        w_fwd_hit;

   assign w_fwd_hit = r_fwd_valid && (data_reqAddr[0:60] == r_fwd_addr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fwd_addr  <= '0;
         r_fwd_data  <= '0;
         r_fwd_valid <= 1'b0;
      end else if ((r_state == S_ST_DATA) && bus_reqack) begin
         r_fwd_addr  <= r_addr;
         r_fwd_data  <= r_data;
         r_fwd_valid <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_beat        <= '0;
         r_addr        <= '0;
         r_data        <= '0;
         r_load_buffer <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (store_reqFlag) begin
                  r_addr  <= store_reqAddr[0:60];
                  r_data  <= store_data;
                  r_state <= S_ST_ADDR;
               end else if (data_reqFlag) begin
                  r_addr <= data_reqAddr[0:60];
`ifdef MEMACCESS_LOAD_FORWARD_EN
                  if (w_fwd_hit) begin
                     r_load_buffer <= r_fwd_data;
                     r_state       <= S_LD_DONE;
                  end else begin
                     r_state <= S_LD_REQ;
                  end
`else
                  r_state <= S_LD_REQ;
`endif
               end
            end
            S_LD_REQ: begin
               if (bus_reqack) begin
                  r_beat  <= '0;
                  r_state <= S_LD_RESP;
               end
            end
            S_LD_RESP: begin
               if (w_beat_ok) begin
                  r_beat <= r_beat + 3'd1;
                  if (r_beat == r_addr[58:60])
                     r_load_buffer <= bus_resp;
                  if (r_beat == LAST_BEAT)
                     r_state <= S_LD_DONE;
               end
            end
            S_LD_DONE: begin
               if (loadbuffer_done)
                  r_state <= S_IDLE;
            end
            S_ST_ADDR: begin
               if (bus_reqack)
                  r_state <= S_ST_DATA;
            end
            S_ST_DATA: begin
               if (bus_reqack)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Loads request the whole line; stores go out doubleword aligned.
   always_comb begin
      w_bus_req = '0;
      case (r_state)
         S_LD_REQ:  w_bus_req = {r_addr[0:57], 6'b0};
         S_ST_ADDR: w_bus_req = {r_addr, 3'b0};
         S_ST_DATA: w_bus_req = r_data;
         default:   w_bus_req = '0;
      endcase
   end

   assign bus_reqcyc            = (r_state == S_LD_REQ) || (r_state == S_ST_ADDR) || (r_state == S_ST_DATA);
   assign bus_req               = w_bus_req;
   assign bus_reqtag            = bus_reqcyc ? {(r_state != S_LD_REQ), DATA_TAG, 12'h0} : 16'h0;
   assign bus_respack           = w_beat_ok;
   assign load_done             = (r_state == S_LD_DONE);
   assign load_buffer           = r_load_buffer;
   assign memstage_active       = (r_state == S_LD_REQ) || (r_state == S_LD_RESP) || (r_state == S_LD_DONE);
   assign store_memstage_active = (r_state == S_ST_ADDR) || (r_state == S_ST_DATA);
   assign store_opn             = store_memstage_active;

endmodule

// File: tb/tb_mod_memaccess.sv
// Directed bench for mod_memaccess: table of loads, stalled stores, priority, foreign tags, async reset, forwarding.
module tb_mod_memaccess;

   logic        clk;
   logic        reset_n;
   logic        data_reqFlag;
   logic [0:63] data_reqAddr;
   logic        store_reqFlag;
   logic [0:63] store_reqAddr;
   logic [0:63] store_data;
   logic        loadbuffer_done;
   logic        load_done;
   logic [0:63] load_buffer;
   logic        memstage_active;
   logic        store_memstage_active;
   logic        store_opn;
   logic        bus_reqcyc;
   logic [0:63] bus_req;
   logic [0:15] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [0:63] bus_resp;
   logic [0:15] bus_resptag;
   logic        bus_respack;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] exp_req;
      logic [63:0] exp_buf;
   } vec_t;

   vec_t vecs [5];

   mod_memaccess dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .data_reqFlag          (data_reqFlag),
      .data_reqAddr          (data_reqAddr),
      .store_reqFlag         (store_reqFlag),
      .store_reqAddr         (store_reqAddr),
      .store_data            (store_data),
      .loadbuffer_done       (loadbuffer_done),
      .load_done             (load_done),
      .load_buffer           (load_buffer),
      .memstage_active       (memstage_active),
      .store_memstage_active (store_memstage_active),
      .store_opn             (store_opn),
      .bus_reqcyc            (bus_reqcyc),
      .bus_req               (bus_req),
      .bus_reqtag            (bus_reqtag),
      .bus_reqack            (bus_reqack),
      .bus_respcyc           (bus_respcyc),
      .bus_resp              (bus_resp),
      .bus_resptag           (bus_resptag),
      .bus_respack           (bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] beat_data(input int i);
      return 64'h1111_1111_1111_1111 * 64'(i + 1);
   endfunction

   // Entered at the negedge of cycle 1 after load acceptance (state LD_REQ).
   task automatic load_phase(input logic [63:0] exp_req, input logic [63:0] exp_buf,
                             input bit foreign, input string nm);
      int k;
      int beat;
      int acks;
      bit is_data;
      logic [63:0] held;
      chk({nm, " reqcyc"}, 64'(bus_reqcyc), 64'd1);
      chk({nm, " req addr"}, bus_req, exp_req);
      chk({nm, " req tag"}, 64'(bus_reqtag), 64'h2000);
      chk({nm, " memstage_active"}, 64'(memstage_active), 64'd1);
      bus_reqack = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b0;
      k = 2; beat = 0; acks = 0;
      if (foreign) loadbuffer_done = 1'b1;
      while (!load_done && k < 60) begin
         is_data     = !(foreign && (k % 2 == 0));
         bus_respcyc = 1'b1;
         bus_resptag = is_data ? 16'h2000 : 16'h6000;
         bus_resp    = is_data ? beat_data(beat) : 64'hBAD0_BAD0_BAD0_BAD0;
         #1;
         if (is_data) acks += int'(bus_respack);
         else chk({nm, " foreign beat not acked"}, 64'(bus_respack), 64'd0);
         @(negedge clk);
         if (is_data) beat++;
         k++;
      end
      bus_respcyc     = 1'b0;
      loadbuffer_done = 1'b0;
      chk({nm, " load_done"}, 64'(load_done), 64'd1);
      if (!foreign) chk({nm, " load latency"}, 64'(k), 64'd10);
      chk({nm, " load_buffer"}, load_buffer, exp_buf);
      chk({nm, " respack count"}, 64'(acks), 64'd8);
      held = load_buffer;
      repeat (2) @(negedge clk);
      chk({nm, " load_done held"}, 64'(load_done), 64'd1);
      chk({nm, " load_buffer stable"}, load_buffer, exp_buf);
      loadbuffer_done = 1'b1;
      @(negedge clk);
      loadbuffer_done = 1'b0;
      chk({nm, " load_done drop"}, 64'(load_done), 64'd0);
      chk({nm, " memstage idle"}, 64'(memstage_active), 64'd0);
      chk({nm, " buffer after consume"}, load_buffer, held);
   endtask

   task automatic do_load(input logic [63:0] addr, input logic [63:0] exp_req,
                          input logic [63:0] exp_buf, input bit foreign, input string nm);
      data_reqFlag = 1'b1;
      data_reqAddr = addr;
      @(posedge clk);
      @(negedge clk);
      data_reqFlag = 1'b0;
      load_phase(exp_req, exp_buf, foreign, nm);
   endtask

   // Entered at the negedge of cycle 1 after store acceptance (state ST_ADDR).
   task automatic store_phase(input logic [63:0] addr, input logic [63:0] data,
                              input int delay, input string nm);
      for (int i = 0; i <= delay; i++) begin
         chk({nm, " addr reqcyc"}, 64'(bus_reqcyc), 64'd1);
         chk({nm, " addr beat"}, bus_req, addr & ~64'h7);
         chk({nm, " addr tag"}, 64'(bus_reqtag), 64'hA000);
         chk({nm, " store_opn addr"}, 64'(store_opn), 64'd1);
         if (i == delay) bus_reqack = 1'b1;
         @(negedge clk);
         bus_reqack = 1'b0;
      end
      for (int i = 0; i <= delay; i++) begin
         chk({nm, " data reqcyc"}, 64'(bus_reqcyc), 64'd1);
         chk({nm, " data beat"}, bus_req, data);
         chk({nm, " store_opn data"}, 64'(store_opn), 64'd1);
         if (i == delay) bus_reqack = 1'b1;
         @(negedge clk);
         bus_reqack = 1'b0;
      end
      chk({nm, " store_opn low"}, 64'(store_opn), 64'd0);
      chk({nm, " reqcyc low"}, 64'(bus_reqcyc), 64'd0);
      chk({nm, " store_memstage low"}, 64'(store_memstage_active), 64'd0);
   endtask

   task automatic do_store(input logic [63:0] addr, input logic [63:0] data,
                           input int delay, input string nm);
      store_reqFlag = 1'b1;
      store_reqAddr = addr;
      store_data    = data;
      @(posedge clk);
      @(negedge clk);
      store_reqFlag = 1'b0;
      store_phase(addr, data, delay, nm);
   endtask

   initial begin
      vecs[0] = '{64'h0000_0000_0000_1018, 64'h0000_0000_0000_1000, 64'h4444_4444_4444_4444};
      vecs[1] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 64'h1111_1111_1111_1111};
      vecs[2] = '{64'h0000_0000_0000_203F, 64'h0000_0000_0000_2000, 64'h8888_8888_8888_8888};
      vecs[3] = '{64'hFFFF_FFFF_FFFF_FFC9, 64'hFFFF_FFFF_FFFF_FFC0, 64'h2222_2222_2222_2222};
      vecs[4] = '{64'h0000_0000_0000_7FF0, 64'h0000_0000_0000_7FC0, 64'h7777_7777_7777_7777};

      reset_n = 1'b0;
      data_reqFlag = 1'b0; data_reqAddr = '0;
      store_reqFlag = 1'b0; store_reqAddr = '0; store_data = '0;
      loadbuffer_done = 1'b0;
      bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
      repeat (2) @(negedge clk);
      chk("reset load_done", 64'(load_done), 64'd0);
      chk("reset load_buffer", load_buffer, 64'h0);
      chk("reset reqcyc", 64'(bus_reqcyc), 64'd0);
      chk("reset bus_req", bus_req, 64'h0);
      chk("reset reqtag", 64'(bus_reqtag), 64'h0);
      chk("reset actives", 64'({memstage_active, store_memstage_active, store_opn, bus_respack}), 64'h0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 5; v++)
         do_load(vecs[v].addr, vecs[v].exp_req, vecs[v].exp_buf, 1'b0, $sformatf("vec%0d", v));

      do_store(64'h2008, 64'hDEAD_BEEF_CAFE_F00D, 3, "store stalled");
      do_store(64'h400F, 64'h0123_4567_89AB_CDEF, 0, "store fast");

      // Both requested together: store first, load still pending afterwards.
      store_reqFlag = 1'b1; store_reqAddr = 64'h5010; store_data = 64'hA5A5_5A5A_0F0F_F0F0;
      data_reqFlag  = 1'b1; data_reqAddr  = 64'h6008;
      @(posedge clk);
      @(negedge clk);
      store_reqFlag = 1'b0;
      chk("prio store first", 64'(store_memstage_active), 64'd1);
      chk("prio load waits", 64'(memstage_active), 64'd0);
      store_phase(64'h5010, 64'hA5A5_5A5A_0F0F_F0F0, 1, "prio store");
      @(posedge clk);
      @(negedge clk);
      data_reqFlag = 1'b0;
      load_phase(64'h6000, 64'h2222_2222_2222_2222, 1'b0, "prio load");

      do_load(64'h1018, 64'h1000, 64'h4444_4444_4444_4444, 1'b1, "foreign");

      // Reset while the fifth beat is on the bus.
      data_reqFlag = 1'b1; data_reqAddr = 64'h1018;
      @(posedge clk);
      @(negedge clk);
      data_reqFlag = 1'b0;
      bus_reqack = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus_respcyc = 1'b1; bus_resptag = 16'h2000; bus_resp = beat_data(b);
         @(negedge clk);
      end
      bus_resp = beat_data(4);
      #1;
      chk("rst beat4 acked", 64'(bus_respack), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("rst respack", 64'(bus_respack), 64'd0);
      chk("rst reqcyc", 64'(bus_reqcyc), 64'd0);
      chk("rst load_buffer", load_buffer, 64'h0);
      chk("rst memstage", 64'(memstage_active), 64'd0);
      chk("rst load_done", 64'(load_done), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst late beat not acked", 64'(bus_respack), 64'd0);
      bus_respcyc = 1'b0;
      @(negedge clk);
      do_load(64'h1018, 64'h1000, 64'h4444_4444_4444_4444, 1'b0, "post reset");

`ifdef MEMACCESS_LOAD_FORWARD_EN
      do_store(64'h3000, 64'h55, 0, "fwd store");
      data_reqFlag = 1'b1; data_reqAddr = 64'h3004;
      @(posedge clk);
      @(negedge clk);
      data_reqFlag = 1'b0;
      chk("fwd load_done", 64'(load_done), 64'd1);
      chk("fwd load_buffer", load_buffer, 64'h55);
      chk("fwd no bus", 64'(bus_reqcyc), 64'd0);
      loadbuffer_done = 1'b1;
      @(negedge clk);
      loadbuffer_done = 1'b0;
      chk("fwd done drop", 64'(load_done), 64'd0);
      chk("fwd still no bus", 64'(bus_reqcyc), 64'd0);
`else
      do_store(64'h3000, 64'h55, 0, "nofwd store");
      do_load(64'h3004, 64'h3000, 64'h1111_1111_1111_1111, 1'b0, "nofwd load");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
